// File: rtl/dac_pkg.sv
// ----------------------------------------------------------------------------
// dac_pkg
// Shared definitions for the TLV5616 sample sequencer.
//   - mode_e        : waveform selection encodings
//   - dir_e         : triangle sweep direction
//   - DATA_W        : DAC code width (TLV5616 is a 12-bit part)
//   - CTRL_SPD_BIT  : position of the speed bit inside the 16-bit word
//   - CTRL_PWR_BIT  : position of the power-down bit inside the 16-bit word
//   - pack_word()   : builds {ctrl[3:0], data[11:0]} for the serializer
// ----------------------------------------------------------------------------
package dac_pkg;

  localparam int DATA_W       = 12;
  localparam int WORD_W       = 16;
  localparam int CTRL_SPD_BIT = 14;
  localparam int CTRL_PWR_BIT = 13;

  typedef enum logic [1:0] {
    MODE_DC   = 2'd0,
    MODE_RAMP = 2'd1,
    MODE_TRI  = 2'd2,
    MODE_SQR  = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // The control nibble is {1'b0, fast, pwr_down, 1'b0}; the two reserved
  // bits must always go out as zero, so start from an all-zero word and
  // only drop in the code and the two live control bits.
  function automatic logic [WORD_W-1:0] pack_word(
    input logic              fast,
    input logic              pwr_down,
    input logic [DATA_W-1:0] data
  );
    logic [WORD_W-1:0] w;
    w               = '0;
    w[DATA_W-1:0]   = data;
    w[CTRL_SPD_BIT] = fast;
    w[CTRL_PWR_BIT] = pwr_down;
    return w;
  endfunction

endpackage

// File: rtl/rate_ticker.sv
// ----------------------------------------------------------------------------
// rate_ticker
// Sample-period divider. Counts 0..rate_div and fires a single-cycle tick
// on the terminal count, then wraps to zero. Held at zero while disabled so
// the first tick after enable arrives rate_div+1 cycles later.
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   en        in   count enable
//   rate_div  in   DIV_W  period minus one
//   tick      out  one-cycle pulse at terminal count (only while en=1)
// ----------------------------------------------------------------------------
module rate_ticker #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] rate_div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;
  logic             at_term;

  // Using >= rather than == means that if rate_div is lowered below the
  // current count, the counter wraps immediately instead of running all the
  // way around the DIV_W range before the next tick.
  assign at_term = (cnt >= rate_div);
  assign tick    = en && at_term;

  // Period counter: cleared by reset and whenever the sequencer is disabled,
  // otherwise advances once per cycle and wraps on the terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en) begin
      cnt <= '0;
    end else if (at_term) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/dac_word_sequencer.sv
// ----------------------------------------------------------------------------
// dac_word_sequencer
// Produces 12-bit DAC codes (DC, ramp, triangle, square) at a programmable
// rate, packs each with the TLV5616 control nibble and offers the resulting
// 16-bit word to the serializer over valid/ready. Samples that arrive while
// the previous word is still unconsumed are dropped and counted.
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   en           in   sequencer enable
//   mode         in   2     0 DC, 1 ramp, 2 triangle, 3 square
//   fast         in   1     TLV5616 speed bit
//   pwr_down     in   1     TLV5616 power-down bit
//   rate_div     in   DIV_W sample period = rate_div+1 cycles
//   step         in   12    ramp/triangle increment
//   level_hi     in   12    upper code limit
//   level_lo     in   12    lower code limit
//   word         out  16    {ctrl[3:0], data[11:0]}
//   word_valid   out  1     word holds an unconsumed sample
//   word_ready   in   1     serializer takes word this cycle
//   overrun      out  1     one-cycle pulse per dropped sample
//   overrun_cnt  out  8     saturating dropped-sample count
//   clr_overrun  in   1     synchronous clear of overrun_cnt
// ----------------------------------------------------------------------------
module dac_word_sequencer #(
  parameter int DIV_W  = 16,
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic              fast,
  input  logic              pwr_down,
  input  logic [DIV_W-1:0]  rate_div,
  input  logic [DATA_W-1:0] step,
  input  logic [DATA_W-1:0] level_hi,
  input  logic [DATA_W-1:0] level_lo,
  output logic [15:0]       word,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              overrun,
  output logic [7:0]        overrun_cnt,
  input  logic              clr_overrun
);

  import dac_pkg::*;

  logic              tick;
  logic [DATA_W-1:0] acc;
  dir_e              dir;
  logic              sq_hi;

  mode_e             cur_mode;
  logic              range_bad;
  logic [DATA_W:0]   acc_plus_step;
  logic [DATA_W:0]   lo_plus_step;
  logic [DATA_W-1:0] sample;
  logic [DATA_W-1:0] acc_nxt;
  dir_e              dir_nxt;
  logic              sq_nxt;

  rate_ticker #(
    .DIV_W (DIV_W)
  ) u_ticker (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .rate_div (rate_div),
    .tick     (tick)
  );

  // One bit wider than the code so that sums near full scale compare
  // correctly instead of wrapping back to small values.
  assign acc_plus_step = {1'b0, acc} + {1'b0, step};
  assign lo_plus_step  = {1'b0, level_lo} + {1'b0, step};
  assign range_bad     = (level_lo > level_hi);

  // Sample selection and next-state computation. The emitted sample is always
  // taken from the current state; the next state is what the waveform moves
  // to once this sample has gone out. An inverted range, or a zero step in
  // the sweeping modes, pins the output at level_lo and parks the state there
  // so that fixing the settings restarts cleanly from the bottom.
  always_comb begin
    cur_mode = mode_e'(mode);
    sample   = acc;
    acc_nxt  = acc;
    dir_nxt  = dir;
    sq_nxt   = sq_hi;
    if (cur_mode == MODE_DC) begin
      sample = level_hi;
    end else if (range_bad || (cur_mode != MODE_SQR && step == '0)) begin
      sample  = level_lo;
      acc_nxt = level_lo;
      dir_nxt = DIR_UP;
      sq_nxt  = 1'b0;
    end else begin
      case (cur_mode)
        MODE_RAMP: begin
          if (acc_plus_step > {1'b0, level_hi}) begin
            acc_nxt = level_lo;
          end else begin
            acc_nxt = acc_plus_step[DATA_W-1:0];
          end
        end
        MODE_TRI: begin
          if (dir == DIR_UP) begin
            if (acc_plus_step >= {1'b0, level_hi}) begin
              acc_nxt = level_hi;
              dir_nxt = DIR_DOWN;
            end else begin
              acc_nxt = acc_plus_step[DATA_W-1:0];
            end
          end else begin
            if ({1'b0, acc} < lo_plus_step) begin
              acc_nxt = level_lo;
              dir_nxt = DIR_UP;
            end else begin
              acc_nxt = acc - step;
            end
          end
        end
        MODE_SQR: begin
          sample = sq_hi ? level_hi : level_lo;
          sq_nxt = ~sq_hi;
        end
        default: begin
          sample = level_hi;
        end
      endcase
    end
  end

  // Waveform state. Disabling the sequencer rewinds to the bottom of the
  // range, sweeping upward, square phase low. The state advances on every
  // tick regardless of whether the output slot could accept the sample, so
  // a stalled serializer does not bend the waveform's timeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      dir   <= DIR_UP;
      sq_hi <= 1'b0;
    end else if (!en) begin
      acc   <= level_lo;
      dir   <= DIR_UP;
      sq_hi <= 1'b0;
    end else if (tick) begin
      acc   <= acc_nxt;
      dir   <= dir_nxt;
      sq_hi <= sq_nxt;
    end
  end

  // Output slot. A tick loads the slot when it is empty or being emptied in
  // the same cycle; otherwise the sample is dropped, the held word is left
  // untouched and the drop is flagged and counted. The control bits are
  // captured alongside the code so a held word never changes underneath the
  // serializer. The clear is written last so it overrides an increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word        <= '0;
      word_valid  <= 1'b0;
      overrun     <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      overrun <= 1'b0;
      if (tick) begin
        if (!word_valid || word_ready) begin
          word       <= pack_word(fast, pwr_down, sample);
          word_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
          if (overrun_cnt != 8'hFF) begin
            overrun_cnt <= overrun_cnt + 8'd1;
          end
        end
      end else if (word_valid && word_ready) begin
        word_valid <= 1'b0;
      end
      if (clr_overrun) begin
        overrun_cnt <= '0;
      end
    end
  end

endmodule
